// File: rtl/exe_stage_pkg.sv
// Shared widths and opcode encoding for the execute stage.
//   DSIZE : datapath width
//   ASIZE : register-file address width
//   OPW   : opcode width
package exe_stage_pkg;

    localparam int unsigned DSIZE = 16;
    localparam int unsigned ASIZE = 5;
    localparam int unsigned OPW   = 3;

    // Shift-amount width for SLL and iteration-counter width for MUL
    localparam int unsigned SHW  = $clog2(DSIZE);
    localparam int unsigned CNTW = $clog2(DSIZE);

    typedef enum logic [OPW-1:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_XOR  = 3'b100,
        OP_SLL  = 3'b101,
        OP_ADDI = 3'b110,
        OP_MUL  = 3'b111
    } opcode_e;

endpackage

// File: rtl/exe_stage_if.sv
// ID/EXE -> EXE -> WB signal bundle.
//   master : upstream/writeback side (drives the instruction, sees the result)
//   slave  : exe_stage (consumes the instruction, drives stall and the result)
interface exe_stage_if;
    import exe_stage_pkg::*;

    logic             in_valid;
    logic [DSIZE-1:0] rdata1_in;
    logic [DSIZE-1:0] rdata2_in;
    logic [DSIZE-1:0] imm_in;
    logic [OPW-1:0]   opcode_in;
    logic [ASIZE-1:0] waddr_in;

    logic             stall;
    logic             wb_valid;
    logic             wen;
    logic [DSIZE-1:0] wdata;
    logic [ASIZE-1:0] waddr_out;

    modport master (
        output in_valid, rdata1_in, rdata2_in, imm_in, opcode_in, waddr_in,
        input  stall, wb_valid, wen, wdata, waddr_out
    );

    modport slave (
        input  in_valid, rdata1_in, rdata2_in, imm_in, opcode_in, waddr_in,
        output stall, wb_valid, wen, wdata, waddr_out
    );

endinterface

// File: rtl/exe_mul_iter.sv
// Iterative shift-add multiplier, one partial product per cycle, DSIZE cycles.
//   clk, rst_n : clock, async active-low reset
//   start      : load operands (only sampled while not busy)
//   a, b       : multiplicand, multiplier
//   busy       : iteration in progress
//   done_c     : final iteration happens on this edge
//   product_c  : accumulator value after the final iteration (valid with done_c)
module exe_mul_iter
    import exe_stage_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DSIZE-1:0] a,
    input  logic [DSIZE-1:0] b,
    output logic             busy,
    output logic             done_c,
    output logic [DSIZE-1:0] product_c
);

    logic [DSIZE-1:0] mcand;
    logic [DSIZE-1:0] mplier;
    logic [DSIZE-1:0] acc;
    logic [CNTW-1:0]  cnt;
    logic [DSIZE-1:0] acc_next_c;

    // Partial-product add for the current multiplier bit
    assign acc_next_c = acc + (mplier[0] ? mcand : '0);
    assign done_c     = busy && (cnt == '0);
    assign product_c  = acc_next_c;

    // Operand load and per-cycle shift-add iteration
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (busy) begin
            acc    <= acc_next_c;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (cnt == '0) begin
                busy <= 1'b0;
            end else begin
                cnt <= cnt - CNTW'(1);
            end
        end else if (start) begin
            busy   <= 1'b1;
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            cnt    <= CNTW'(DSIZE - 1);
        end
    end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: single-cycle ALU plus iterative MUL, registered EXE/WB outputs.
//   clk, rst_n : clock, async active-low reset
//   bus        : exe_stage_if.slave -- instruction in, stall/result out
module exe_stage
    import exe_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    exe_stage_if.slave  bus
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic             stall_q, stall_d;
    logic             wb_valid_q, wb_valid_d;
    logic [DSIZE-1:0] wdata_q, wdata_d;
    logic [ASIZE-1:0] waddr_q, waddr_d;
    logic [ASIZE-1:0] mul_waddr_q, mul_waddr_d;

    logic             mul_start_c;
    logic             mul_busy;
    logic             mul_done_c;
    logic [DSIZE-1:0] mul_product_c;
    logic [DSIZE-1:0] alu_c;

    exe_mul_iter u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (mul_start_c),
        .a         (bus.rdata1_in),
        .b         (bus.rdata2_in),
        .busy      (mul_busy),
        .done_c    (mul_done_c),
        .product_c (mul_product_c)
    );

    // Single-cycle ALU; MUL goes through the iterative unit instead
    always_comb begin
        alu_c = '0;
        case (bus.opcode_in)
            OP_ADD:  alu_c = bus.rdata1_in + bus.rdata2_in;
            OP_SUB:  alu_c = bus.rdata1_in - bus.rdata2_in;
            OP_AND:  alu_c = bus.rdata1_in & bus.rdata2_in;
            OP_OR:   alu_c = bus.rdata1_in | bus.rdata2_in;
            OP_XOR:  alu_c = bus.rdata1_in ^ bus.rdata2_in;
            OP_SLL:  alu_c = bus.rdata1_in << bus.rdata2_in[SHW-1:0];
            OP_ADDI: alu_c = bus.rdata1_in + bus.imm_in;
            default: alu_c = '0;
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        mul_start_c = 1'b0;
        wb_valid_d  = 1'b0;
        wdata_d     = wdata_q;
        waddr_d     = waddr_q;
        mul_waddr_d = mul_waddr_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (bus.opcode_in == OP_MUL) begin
                        mul_start_c = 1'b1;
                        mul_waddr_d = bus.waddr_in;
                        state_d     = BUSY;
                    end else begin
                        wb_valid_d = 1'b1;
                        wdata_d    = alu_c;
                        waddr_d    = bus.waddr_in;
                    end
                end
            end
            BUSY: begin
                // Inputs are held upstream and ignored until the product retires
                if (mul_done_c) begin
                    wb_valid_d = 1'b1;
                    wdata_d    = mul_product_c;
                    waddr_d    = mul_waddr_q;
                    state_d    = IDLE;
                end else if (!mul_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        stall_d = (state_d == BUSY);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            stall_q     <= 1'b0;
            wb_valid_q  <= 1'b0;
            wdata_q     <= '0;
            waddr_q     <= '0;
            mul_waddr_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_q     <= stall_d;
            wb_valid_q  <= wb_valid_d;
            wdata_q     <= wdata_d;
            waddr_q     <= waddr_d;
            mul_waddr_q <= mul_waddr_d;
        end
    end

    assign bus.stall     = stall_q;
    assign bus.wb_valid  = wb_valid_q;
    assign bus.wen       = wb_valid_q;
    assign bus.wdata     = wdata_q;
    assign bus.waddr_out = waddr_q;

endmodule

// File: tb/tb_exe_stage.sv
// Testbench for exe_stage: directed scenarios plus a randomized instruction
// stream scored against a schedule/arithmetic reference model.
module tb_exe_stage;
    import exe_stage_pkg::*;

    localparam int NRND = 40;
    localparam int LAT  = 16;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    exe_stage_if bus ();

    exe_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Random-stream storage and its expected schedule
    logic        r_v  [NRND];
    logic [2:0]  r_op [NRND];
    logic [15:0] r_a  [NRND];
    logic [15:0] r_b  [NRND];
    logic [15:0] r_i  [NRND];
    logic [4:0]  r_w  [NRND];
    int          r_acc[NRND];
    int          r_res[NRND];

    function automatic logic [15:0] ref_result(input logic [2:0] op, input logic [15:0] a,
                                               input logic [15:0] b, input logic [15:0] imm);
        int unsigned ua, ub, ui;
        int unsigned r;
        ua = a; ub = b; ui = imm;
        case (op)
            3'd0:    r = ua + ub;
            3'd1:    r = ua - ub;
            3'd2:    r = ua & ub;
            3'd3:    r = ua | ub;
            3'd4:    r = ua ^ ub;
            3'd5:    r = ua * (32'd1 << (ub % 16));
            3'd6:    r = ua + ui;
            default: r = ua * ub;
        endcase
        return r[15:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic present(input logic v, input logic [2:0] op, input logic [15:0] a,
                           input logic [15:0] b, input logic [15:0] imm, input logic [4:0] wa);
        bus.in_valid  = v;
        bus.opcode_in = op;
        bus.rdata1_in = a;
        bus.rdata2_in = b;
        bus.imm_in    = imm;
        bus.waddr_in  = wa;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single-cycle op: result expected right after the presenting edge
    task automatic alu_step(input string tag, input logic [2:0] op, input logic [15:0] a,
                            input logic [15:0] b, input logic [15:0] imm, input logic [4:0] wa,
                            input logic [15:0] exp_d);
        present(1'b1, op, a, b, imm, wa);
        tick();
        chk({tag, "_wb"}, 32'(bus.wb_valid), 32'd1);
        chk({tag, "_wen"}, 32'(bus.wen), 32'd1);
        chk({tag, "_wdata"}, 32'(bus.wdata), 32'(exp_d));
        chk({tag, "_waddr"}, 32'(bus.waddr_out), 32'(wa));
        chk({tag, "_stall"}, 32'(bus.stall), 32'd0);
    endtask

    // MUL accept, then the following instruction is held while busy
    task automatic mul_step(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic [4:0] wa, input logic [15:0] exp_d,
                            input logic nv, input logic [2:0] nop, input logic [15:0] na,
                            input logic [15:0] nb, input logic [4:0] nwa);
        int stall_cnt;
        int early_wb;
        present(1'b1, 3'd7, a, b, 16'h0, wa);
        tick();
        present(nv, nop, na, nb, 16'h0, nwa);
        stall_cnt = 0;
        early_wb  = 0;
        for (int k = 0; k < LAT; k++) begin
            if (bus.stall === 1'b1) stall_cnt++;
            if (bus.wb_valid !== 1'b0) early_wb++;
            if (k < LAT - 1) tick();
        end
        chk({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(LAT));
        chk({tag, "_no_early_wb"}, 32'(early_wb), 32'd0);
        tick();
        chk({tag, "_wb"}, 32'(bus.wb_valid), 32'd1);
        chk({tag, "_wdata"}, 32'(bus.wdata), 32'(exp_d));
        chk({tag, "_waddr"}, 32'(bus.waddr_out), 32'(wa));
        chk({tag, "_stall_low"}, 32'(bus.stall), 32'd0);
    endtask

    initial begin
        int nxt, p, last_e;
        logic        exp_wb, exp_stall;
        logic [15:0] exp_d;
        logic [4:0]  exp_w;

        rst_n = 1'b0;
        present(1'b0, 3'd0, 16'h0, 16'h0, 16'h0, 5'd0);
        #12;
        chk("rst_stall", 32'(bus.stall), 32'd0);
        chk("rst_wb", 32'(bus.wb_valid), 32'd0);
        chk("rst_wen", 32'(bus.wen), 32'd0);
        chk("rst_wdata", 32'(bus.wdata), 32'd0);
        chk("rst_waddr", 32'(bus.waddr_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: ADD wraps modulo 2^16, then a bubble holds wdata/waddr
        alu_step("t1_add", 3'd0, 16'hFFFF, 16'h0001, 16'h0, 5'd3, 16'h0000);
        present(1'b0, 3'd0, 16'h1234, 16'h1111, 16'h0, 5'd9);
        tick();
        chk("t1_bub_wb", 32'(bus.wb_valid), 32'd0);
        chk("t1_bub_wdata", 32'(bus.wdata), 32'h0000);
        chk("t1_bub_waddr", 32'(bus.waddr_out), 32'd3);
        chk("t1_bub_stall", 32'(bus.stall), 32'd0);

        // 2: SUB then ADDI on consecutive cycles
        alu_step("t2_sub", 3'd1, 16'h0003, 16'h0005, 16'h0, 5'd4, 16'hFFFE);
        alu_step("t2_addi", 3'd6, 16'h0010, 16'h0000, 16'hFFFF, 5'd5, 16'h000F);

        // Remaining single-cycle ops, including SLL using only B[3:0]
        alu_step("t2_or", 3'd3, 16'hA000, 16'h000A, 16'h0, 5'd6, 16'hA00A);
        alu_step("t2_xor", 3'd4, 16'hFF00, 16'h0FF0, 16'h0, 5'd8, 16'hF0F0);
        alu_step("t2_sll", 3'd5, 16'h0003, 16'h0014, 16'h0, 5'd1, 16'h0030);

        // 3: MUL followed by a held AND, retired exactly once
        mul_step("t3_mul", 16'h0012, 16'h0034, 5'd7, 16'h03A8, 1'b1, 3'd2, 16'h00F0, 16'h0FF0, 5'd2);
        present(1'b1, 3'd2, 16'h00F0, 16'h0FF0, 16'h0, 5'd2);
        tick();
        chk("t3_and_wb", 32'(bus.wb_valid), 32'd1);
        chk("t3_and_wdata", 32'(bus.wdata), 32'h00F0);
        chk("t3_and_waddr", 32'(bus.waddr_out), 32'd2);
        present(1'b0, 3'd0, 16'h0, 16'h0, 16'h0, 5'd0);
        tick();
        chk("t3_once", 32'(bus.wb_valid), 32'd0);

        // 4: MUL overflow cases
        mul_step("t4_mul0", 16'h0100, 16'h0100, 5'd10, 16'h0000, 1'b0, 3'd0, 16'h0, 16'h0, 5'd0);
        mul_step("t4_mulF", 16'hFFFF, 16'hFFFF, 5'd11, 16'h0001, 1'b0, 3'd0, 16'h0, 16'h0, 5'd0);
        mul_step("t4_mulz", 16'h1234, 16'h0000, 5'd12, 16'h0000, 1'b0, 3'd0, 16'h0, 16'h0, 5'd0);

        // 5: reset during MUL aborts it
        present(1'b1, 3'd7, 16'h0007, 16'h0009, 16'h0, 5'd13);
        tick();
        present(1'b0, 3'd0, 16'h0, 16'h0, 16'h0, 5'd0);
        repeat (4) tick();
        chk("t5_busy", 32'(bus.stall), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_stall", 32'(bus.stall), 32'd0);
        chk("t5_rst_wb", 32'(bus.wb_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        alu_step("t5_add", 3'd0, 16'h0002, 16'h0002, 16'h0, 5'd14, 16'h0004);
        present(1'b0, 3'd0, 16'h0, 16'h0, 16'h0, 5'd0);
        repeat (LAT + 2) begin
            tick();
            if (bus.wb_valid !== 1'b0) chk("t5_no_ghost", 32'(bus.wb_valid), 32'd0);
        end

        // 6: back-to-back MULs with one low stall cycle between
        mul_step("t6_mul1", 16'h0003, 16'h0004, 5'd15, 16'h000C, 1'b1, 3'd7, 16'h0005, 16'h0006, 5'd16);
        mul_step("t6_mul2", 16'h0005, 16'h0006, 5'd16, 16'h001E, 1'b0, 3'd0, 16'h0, 16'h0, 5'd0);
        present(1'b0, 3'd0, 16'h0, 16'h0, 16'h0, 5'd0);
        tick();
        chk("t6_tail_wb", 32'(bus.wb_valid), 32'd0);

        // Random stream: each instruction is accepted on the first free edge;
        // a result follows its accept edge, or 16 edges later for MUL.
        nxt = 0;
        for (int i = 0; i < NRND; i++) begin
            r_v[i]   = ($urandom_range(0, 4) != 0);
            r_op[i]  = 3'($urandom_range(0, 7));
            r_a[i]   = 16'($urandom);
            r_b[i]   = 16'($urandom);
            r_i[i]   = 16'($urandom);
            r_w[i]   = 5'($urandom);
            r_acc[i] = nxt;
            if (r_v[i] && r_op[i] == 3'd7) begin
                r_res[i] = nxt + LAT;
                nxt      = nxt + LAT + 1;
            end else begin
                r_res[i] = r_v[i] ? nxt : -1;
                nxt      = nxt + 1;
            end
        end
        last_e = nxt + 1;
        p = 0;
        for (int e = 0; e <= last_e; e++) begin
            while (p < NRND && r_acc[p] < e) p++;
            if (p < NRND) present(r_v[p], r_op[p], r_a[p], r_b[p], r_i[p], r_w[p]);
            else          present(1'b0, 3'd0, 16'h0, 16'h0, 16'h0, 5'd0);
            tick();
            exp_wb    = 1'b0;
            exp_stall = 1'b0;
            exp_d     = '0;
            exp_w     = '0;
            for (int i = 0; i < NRND; i++) begin
                if (r_v[i] && r_res[i] == e) begin
                    exp_wb = 1'b1;
                    exp_d  = ref_result(r_op[i], r_a[i], r_b[i], r_i[i]);
                    exp_w  = r_w[i];
                end
                if (r_v[i] && r_op[i] == 3'd7 && e >= r_acc[i] && e <= r_acc[i] + LAT - 1)
                    exp_stall = 1'b1;
            end
            chk("rnd_wb", 32'(bus.wb_valid), 32'(exp_wb));
            chk("rnd_stall", 32'(bus.stall), 32'(exp_stall));
            if (exp_wb) begin
                chk("rnd_wdata", 32'(bus.wdata), 32'(exp_d));
                chk("rnd_waddr", 32'(bus.waddr_out), 32'(exp_w));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
